// File: rtl/rf_sb_param.sv
// Register file with two async read ports, one write port, optional bypass,
// and a per-register pending-write scoreboard that flags RAW hazards.

// Per-read-port logic: zero-register masking, write forwarding, hazard detect
module rf_sb_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              used,
    input  logic [DATA_W-1:0] rdata,
    input  logic              busy_bit,
    input  logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] data,
    output logic              hazard
);
    logic fwd, is_zero;

    // Forward this cycle's write-back; it also resolves the pending write
    always_comb begin
        fwd     = (BYPASS != 0) && RegWrite && (RdAddr == addr);
        is_zero = (ZERO_REG != 0) && (addr == '0);
        data    = is_zero ? '0 : (fwd ? RdData : rdata);
        hazard  = used && busy_bit && !fwd;
    end
endmodule

module rf_sb_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    input  logic              RsUsed,
    input  logic              RtUsed,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    input  logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RegWrite,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueAddr,
    output logic              IssueAck,
    output logic              Stall,
    output logic [ADDR_W:0]   BusyCount
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NRP   = 2;

    logic [DATA_W-1:0]          regs [DEPTH];
    logic [DEPTH-1:0]           busy, busy_nxt;
    logic [ADDR_W:0]            cnt_nxt;
    logic                       wb_ok, iss_ok;

    logic [NRP-1:0][ADDR_W-1:0] rp_addr;
    logic [NRP-1:0]             rp_used, rp_haz;
    logic [NRP-1:0][DATA_W-1:0] rp_data;

    // Port 0 is Rs, port 1 is Rt
    assign rp_addr = {RtAddr, RsAddr};
    assign rp_used = {RtUsed, RsUsed};
    assign RsData  = rp_data[0];
    assign RtData  = rp_data[1];

    genvar p;
    generate
        for (p = 0; p < NRP; p++) begin : g_rp
            rf_sb_rdport #(
                .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
            ) u_rp (
                .addr    (rp_addr[p]),
                .used    (rp_used[p]),
                .rdata   (regs[rp_addr[p]]),
                .busy_bit(busy[rp_addr[p]]),
                .RdAddr  (RdAddr),
                .RdData  (RdData),
                .RegWrite(RegWrite),
                .data    (rp_data[p]),
                .hazard  (rp_haz[p])
            );
        end
    endgenerate

    assign Stall    = |rp_haz;
    assign IssueAck = IssueValid & ~Stall;

    // Next scoreboard: write-back clears, accepted issue sets; set applied last so it wins
    always_comb begin
        wb_ok    = RegWrite && !((ZERO_REG != 0) && (RdAddr == '0));
        iss_ok   = IssueAck && !((ZERO_REG != 0) && (IssueAddr == '0));
        busy_nxt = busy;
        if (wb_ok)  busy_nxt[RdAddr]    = 1'b0;
        if (iss_ok) busy_nxt[IssueAddr] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end

    // Register array write; reset clears every entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[RdAddr] <= RdData;
        end
    end

    // Scoreboard and its registered population count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= '0;
            BusyCount <= '0;
        end else begin
            busy      <= busy_nxt;
            BusyCount <= cnt_nxt;
        end
    end
endmodule
